// File: rtl/fpu_types_pkg.sv
// Shared half-precision types and constants for the FPU datapath, plus the
// divider's state and flag types.
package fpu_types_pkg;

  localparam int HALF_FLOAT_W    = 16;
  localparam int HALF_EXPONENT_W = 5;
  localparam int HALF_FRACTION_W = 10;
  localparam int HALF_EXP_BIAS   = 15;

  localparam logic [HALF_FLOAT_W-1:0] HALF_ZERO = 16'h0000;
  localparam logic [HALF_FLOAT_W-1:0] HALF_QNAN = 16'hFFFF;

  typedef logic [HALF_EXPONENT_W-1:0] exp_t;
  typedef logic [HALF_FRACTION_W:0]   mant_t;  // includes the hidden bit

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PREP   = 3'd1,
    DIVIDE = 3'd2,
    ROUND  = 3'd3,
    DONE   = 3'd4
  } div_state_t;

  typedef struct packed {
    logic invalid;
    logic div_by_zero;
    logic overflow;
    logic underflow;
  } fp_flags_t;

  function automatic logic is_nan(input logic [HALF_FLOAT_W-1:0] x);
    return (&x[14:10]) & (|x[9:0]);
  endfunction

  function automatic logic is_inf(input logic [HALF_FLOAT_W-1:0] x);
    return (&x[14:10]) & ~(|x[9:0]);
  endfunction

  function automatic logic is_zero(input logic [HALF_FLOAT_W-1:0] x);
    return ~(|x[14:0]);
  endfunction

endpackage

// File: rtl/lzc_10bit.sv
// Leading-zero count of a 10-bit fraction field; an all-zero input reports 10.
module lzc_10bit (
  input  logic [9:0] mant,
  output logic [3:0] count
);

  // Ascending scan: the highest set bit is the last to write the count.
  always_comb begin
    count = 4'd10;
    for (int i = 0; i < 10; i++) begin
      if (mant[i]) count = 4'(9 - i);
    end
  end

endmodule

// File: rtl/float_div_16bit_seq.sv
// Iterative binary16 divider: restoring radix-2 mantissa division, one quotient
// bit per cycle, round-to-nearest-even, subnormal results flushed to zero.
module float_div_16bit_seq
  import fpu_types_pkg::*;
#(
  parameter int QBITS = 14,
  parameter int CNT_W = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [HALF_FLOAT_W-1:0] dividend,
  input  logic [HALF_FLOAT_W-1:0] divisor,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [HALF_FLOAT_W-1:0] quotient,
  output logic [3:0]              flags,
  output div_state_t              dbg_state
);

  // Handshake: an input transfer happens on a rising edge where in_valid and
  // in_ready are both high; an output transfer on a rising edge where
  // out_valid and out_ready are both high. in_ready is high only in IDLE,
  // out_valid only in DONE, and quotient/flags never change while out_valid=1.

  div_state_t              state;
  logic [HALF_FLOAT_W-1:0] a_q, b_q;
  logic                    sign_q;
  logic signed [6:0]       e_q;
  mant_t                   m2_q;
  logic [11:0]             rem_q;
  logic [QBITS-1:0]        q_q;
  logic [CNT_W-1:0]        cnt_q;
  fp_flags_t               flags_q;

  assign flags     = flags_q;
  assign dbg_state = state;

  // Operand decode and normalisation.
  logic [3:0]        lzc_a, lzc_b;
  exp_t              ea_raw, eb_raw;
  mant_t             m1_norm, m2_norm;
  logic signed [6:0] e1_s, e2_s, e_pre;
  logic              sign_pre;

  lzc_10bit u_lzc_a (.mant(a_q[9:0]), .count(lzc_a));
  lzc_10bit u_lzc_b (.mant(b_q[9:0]), .count(lzc_b));

  // A subnormal fraction with lzc leading zeros needs lzc+1 shifts to put its
  // leading one at the hidden-bit position; its true exponent is then -lzc.
  always_comb begin
    ea_raw   = a_q[14:10];
    eb_raw   = b_q[14:10];
    sign_pre = a_q[15] ^ b_q[15];
    if (ea_raw == '0) begin
      m1_norm = mant_t'({1'b0, a_q[9:0]} << (lzc_a + 4'd1));
      e1_s    = -$signed({3'b000, lzc_a});
    end else begin
      m1_norm = {1'b1, a_q[9:0]};
      e1_s    = $signed({2'b00, ea_raw});
    end
    if (eb_raw == '0) begin
      m2_norm = mant_t'({1'b0, b_q[9:0]} << (lzc_b + 4'd1));
      e2_s    = -$signed({3'b000, lzc_b});
    end else begin
      m2_norm = {1'b1, b_q[9:0]};
      e2_s    = $signed({2'b00, eb_raw});
    end
    e_pre = e1_s - e2_s + 7'(HALF_EXP_BIAS);
  end

  // Special-operand detection, in priority order.
  logic                    special;
  logic [HALF_FLOAT_W-1:0] special_res;
  fp_flags_t               special_flags;

  always_comb begin
    special       = 1'b1;
    special_res   = HALF_QNAN;
    special_flags = '0;
    if (is_nan(a_q) || is_nan(b_q) || (is_zero(a_q) && is_zero(b_q)) ||
        (is_inf(a_q) && is_inf(b_q))) begin
      special_res           = HALF_QNAN;
      special_flags.invalid = 1'b1;
    end else if (is_zero(b_q) && !is_inf(a_q)) begin
      special_res               = {sign_pre, 5'h1F, 10'h000};
      special_flags.div_by_zero = 1'b1;
    end else if (is_inf(a_q)) begin
      special_res = {sign_pre, 5'h1F, 10'h000};
    end else if (is_zero(a_q) || is_inf(b_q)) begin
      special_res = {sign_pre, HALF_ZERO[14:0]};
    end else begin
      special = 1'b0;
    end
  end

  // One restoring step.
  logic        rem_ge;
  logic [11:0] rem_sub;

  always_comb begin
    rem_ge  = rem_q >= {1'b0, m2_q};
    rem_sub = rem_ge ? (rem_q - {1'b0, m2_q}) : rem_q;
  end

  // Rounding: pick the 10 fraction bits below the leading quotient one.
  logic [9:0]              frac_pre;
  logic                    guard, sticky, round_up;
  logic [10:0]             frac_inc;
  logic signed [6:0]       e_adj, e_fin;
  logic [HALF_FLOAT_W-1:0] round_res;
  fp_flags_t               round_flags;

  always_comb begin
    if (q_q[QBITS-1]) begin
      frac_pre = q_q[QBITS-2 -: 10];
      guard    = q_q[QBITS-12];
      sticky   = (|q_q[QBITS-13:0]) | (|rem_q);
      e_adj    = e_q;
    end else begin
      frac_pre = q_q[QBITS-3 -: 10];
      guard    = q_q[QBITS-13];
      sticky   = (|q_q[QBITS-14:0]) | (|rem_q);
      e_adj    = e_q - 7'sd1;
    end
    round_up    = guard & (sticky | frac_pre[0]);
    frac_inc    = {1'b0, frac_pre} + {10'd0, round_up};
    e_fin       = frac_inc[10] ? (e_adj + 7'sd1) : e_adj;
    round_flags = '0;
    if (e_fin >= 7'sd31) begin
      round_res            = {sign_q, 5'h1F, 10'h000};
      round_flags.overflow = 1'b1;
    end else if (e_fin <= 7'sd0) begin
      round_res             = {sign_q, HALF_ZERO[14:0]};
      round_flags.underflow = 1'b1;
    end else begin
      round_res = {sign_q, e_fin[4:0], frac_inc[9:0]};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= HALF_ZERO;
      flags_q   <= '0;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sign_q    <= 1'b0;
      e_q       <= '0;
      m2_q      <= '0;
      rem_q     <= '0;
      q_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= dividend;
            b_q      <= divisor;
            flags_q  <= '0;
            in_ready <= 1'b0;
            state    <= PREP;
          end
        end
        PREP: begin
          sign_q <= sign_pre;
          e_q    <= e_pre;
          m2_q   <= m2_norm;
          rem_q  <= {1'b0, m1_norm};
          q_q    <= '0;
          cnt_q  <= '0;
          if (special) begin
            quotient  <= special_res;
            flags_q   <= special_flags;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            state <= DIVIDE;
          end
        end
        DIVIDE: begin
          rem_q <= {rem_sub[10:0], 1'b0};
          q_q   <= {q_q[QBITS-2:0], rem_ge};
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(QBITS - 1)) state <= ROUND;
        end
        ROUND: begin
          quotient  <= round_res;
          flags_q   <= round_flags;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_float_div_16bit_seq.sv
// Bench for float_div_16bit_seq: directed and random divisions through a
// scoreboard, latency, backpressure and mid-operation reset.
module tb_float_div_16bit_seq;
  import fpu_types_pkg::*;

  logic        CLK, RST;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] dividend, divisor, quotient;
  logic [3:0]  flags;
  div_state_t  dbg_state;

  float_div_16bit_seq dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .flags(flags),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard entries are {flags, quotient}; latency kept alongside.
  logic [19:0] exp_q[$];
  int          lat_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: long integer division of the normalised mantissas, then RNE.
  function automatic logic [19:0] ref_div(input logic [15:0] a, input logic [15:0] b);
    logic [35:0] num, qt, rm, fr, rb, half;
    int          e, sh;
    logic        up, sgn;
    sgn  = a[15] ^ b[15];
    e    = int'(a[14:10]) - int'(b[14:10]) + 15;
    num  = {25'd1, a[9:0]} << 24;
    qt   = num / {25'd1, b[9:0]};
    rm   = num % {25'd1, b[9:0]};
    if (qt >= (36'd1 << 24)) sh = 14;
    else begin sh = 13; e = e - 1; end
    fr   = qt >> sh;
    rb   = qt & ((36'd1 << sh) - 36'd1);
    half = 36'd1 << (sh - 1);
    up   = (rb > half) || ((rb == half) && ((rm != 0) || fr[0]));
    fr   = fr + {35'd0, up};
    if (fr == 36'd2048) begin fr = 36'd1024; e = e + 1; end
    if (e >= 31)     return {4'b0010, sgn, 5'h1F, 10'h000};
    else if (e <= 0) return {4'b0001, sgn, 15'h0000};
    else             return {4'b0000, sgn, 5'(e), fr[9:0]};
  endfunction

  task automatic do_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  // Driver + monitor for one operation; hold = cycles of out_ready=0 after out_valid.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input logic [19:0] exp_res, input int exp_lat, input int hold);
    int          lat, waited;
    logic [19:0] e_res;
    int          e_lat;
    logic [15:0] q0;
    logic [3:0]  f0;
    waited = 0;
    while (!in_ready && waited < 50) begin @(posedge CLK); #1; waited++; end
    if (!in_ready) begin
      check_eq("in_ready_timeout", 32'(in_ready), 32'd1);
      do_reset();
    end
    exp_q.push_back(exp_res);
    lat_q.push_back(exp_lat);
    dividend = a; divisor = b; in_valid = 1'b1;
    @(posedge CLK);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin @(posedge CLK); #1; lat++; end
    e_res = exp_q.pop_front();
    e_lat = lat_q.pop_front();
    if (!out_valid) begin
      check_eq("out_valid_timeout", 32'(out_valid), 32'd1);
      do_reset();
      return;
    end
    check_eq("latency", 32'(lat), 32'(e_lat));
    check_eq("quotient", 32'(quotient), 32'(e_res[15:0]));
    check_eq("flags", 32'(flags), 32'(e_res[19:16]));
    q0 = quotient; f0 = flags;
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK); #1;
      check_eq("hold_quotient", 32'(quotient), 32'(q0));
      check_eq("hold_flags", 32'(flags), 32'(f0));
      check_eq("hold_valid_ready", {30'd0, out_valid, in_ready}, 32'b10);
    end
    out_ready = 1'b1;
    @(posedge CLK);
    #1 out_ready = 1'b0;
    check_eq("release_valid_ready", {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  typedef struct {
    logic [15:0] a, b, q;
    logic [3:0]  f;
    int          lat;
  } vec_t;

  vec_t vecs[10] = '{
    '{16'h3C00, 16'h3C00, 16'h3C00, 4'b0000, 17},
    '{16'h4600, 16'h4000, 16'h4200, 4'b0000, 17},
    '{16'h3C00, 16'h4200, 16'h3555, 4'b0000, 17},
    '{16'h0001, 16'h0001, 16'h3C00, 4'b0000, 17},
    '{16'h3C00, 16'h0000, 16'h7C00, 4'b0100, 2},
    '{16'h0000, 16'h0000, 16'hFFFF, 4'b1000, 2},
    '{16'h7E00, 16'h3C00, 16'hFFFF, 4'b1000, 2},
    '{16'hC000, 16'h7C00, 16'h8000, 4'b0000, 2},
    '{16'h7BFF, 16'h0400, 16'h7C00, 4'b0010, 17},
    '{16'h0400, 16'h7BFF, 16'h0000, 4'b0001, 17}
  };

  initial begin
    logic [15:0] ra, rb;
    RST = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0;
    do_reset();
    check_eq("reset_quotient", 32'(quotient), 32'h0);
    check_eq("reset_flags", 32'(flags), 32'h0);
    check_eq("reset_valid_ready", {30'd0, out_valid, in_ready}, 32'b01);
    check_eq("reset_state", 32'(dbg_state), 32'(IDLE));

    foreach (vecs[i])
      do_op(vecs[i].a, vecs[i].b, {vecs[i].f, vecs[i].q}, vecs[i].lat, 0);

    // Backpressure, then a back-to-back operation.
    do_op(16'h4600, 16'h4000, {4'b0000, 16'h4200}, 17, 5);
    do_op(16'h3C00, 16'h4200, {4'b0000, 16'h3555}, 17, 0);

    // Reset during DIVIDE aborts without a result.
    dividend = 16'h4600; divisor = 16'h4000; in_valid = 1'b1;
    @(posedge CLK);
    #1 in_valid = 1'b0;
    repeat (7) @(posedge CLK);
    #1;
    check_eq("mid_state", 32'(dbg_state), 32'(DIVIDE));
    RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    check_eq("abort_valid_ready", {30'd0, out_valid, in_ready}, 32'b01);
    check_eq("abort_state", 32'(dbg_state), 32'(IDLE));
    do_op(16'h4600, 16'h4000, {4'b0000, 16'h4200}, 17, 0);

    // Random normal operands.
    for (int i = 0; i < 16; i++) begin
      ra = {1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)), 10'($urandom_range(0, 1023))};
      rb = {1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)), 10'($urandom_range(0, 1023))};
      do_op(ra, rb, ref_div(ra, rb), 17, $urandom_range(0, 2));
    end

    check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
